// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
// Holds the state encoding, the step count and the adder carry helper.
package mult16_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH = 16;
   localparam int STEPS = 16;

   // The adder has no carry-out, so recover it from the operand and sum MSBs.
   function automatic logic carry_msb(input logic x15, input logic y15, input logic s15);
      return (x15 & y15) | ((x15 | y15) & ~s15);
   endfunction

endpackage

// File: rtl/mult16_seq_add16.sv
// Plain 16-bit adder, sum only (no carry-out); combinational.
module mult16_seq_add16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] s
);

   assign s = x + y;

endmodule

// File: rtl/mult16_seq.sv
// Unsigned 16x16 -> 32 sequential multiplier, one multiplier bit per clock.
// Result registered on {hi,out}; done pulses one cycle after 16 RUN steps.
module mult16_seq
   import mult16_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] out,
   output logic [15:0] hi,
   output logic        busy,
   output logic        done
);

   state_t      state_q, state_d;
   logic [15:0] mcand_q;
   logic [15:0] mplier_q;
   logic [15:0] acc_hi_q, acc_lo_q;
   logic [4:0]  cnt_q;

   logic [15:0] add_y;
   logic [15:0] sum;
   logic        carry;
   logic [15:0] acc_hi_d, acc_lo_d;
   logic        last_step;
   logic        accept;

   assign add_y = mplier_q[0] ? mcand_q : 16'd0;

   mult16_seq_add16 u_add16 (
      .x (acc_hi_q),
      .y (add_y),
      .s (sum)
   );

   assign carry     = carry_msb(acc_hi_q[15], add_y[15], sum[15]);
   assign acc_hi_d  = {carry, sum[15:1]};
   assign acc_lo_d  = {sum[0], acc_lo_q[15:1]};
   assign last_step = (cnt_q == 5'(STEPS - 1));

   // DONE also takes a waiting start so back-to-back ops issue every 17 clocks.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_step) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         out      <= '0;
         hi       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         done    <= (state_d == DONE);
         if (accept) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
         end else if (state_q == RUN) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mplier_q <= {1'b0, mplier_q[15:1]};
            cnt_q    <= cnt_q + 5'd1;
            if (last_step) begin
               out <= acc_lo_d;
               hi  <= acc_hi_d;
            end
         end
      end
   end

endmodule
